// File: rtl/slice_pkg.sv
// slice_pkg: shared types and constants for the frame slicer.
//   code_rate_e : CODE_RATE_2 = rate 1/2 (2 bits/symbol), CODE_RATE_3 = rate 1/3
//   state_e     : slicer FSM states
//   MAX_RATE    : bits per output symbol slot
package slice_pkg;
  localparam int MAX_RATE = 3;

  typedef enum logic {
    CODE_RATE_2 = 1'b0,
    CODE_RATE_3 = 1'b1
  } code_rate_e;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;
endpackage

// File: rtl/slice_beat_extract.sv
// slice_beat_extract: maps the top SYM_PER_BEAT*MAX_RATE shift-register bits
// to one output beat.
//   i_top   : top bits of the shift register, i_top[TOPW-1] is the earliest bit
//   i_rate  : latched code rate
//   i_rem   : bits of the frame still to be emitted (including this beat)
//   o_rx    : symbol j in [j*MAX_RATE +: MAX_RATE], earliest bit in slot bit 0
//   o_erase : symbol j lies wholly past the end of the frame (SLICE_ERASE_EN only)
// Optional feature macro: SLICE_ERASE_EN.
module slice_beat_extract #(
  parameter int SYM_PER_BEAT = 2,
  parameter int MAX_RATE     = 3,
  parameter int LEN_W        = 9
) (
  input  logic [SYM_PER_BEAT*MAX_RATE-1:0] i_top,
  input  slice_pkg::code_rate_e            i_rate,
  input  logic [LEN_W-1:0]                 i_rem,
`ifdef SLICE_ERASE_EN
  output logic [SYM_PER_BEAT-1:0]          o_erase,
`endif
  output logic [SYM_PER_BEAT*MAX_RATE-1:0] o_rx
);
  import slice_pkg::*;

  localparam int TOPW = SYM_PER_BEAT * MAX_RATE;

  always_comb begin
    int r;
    int p;
    int rem_i;
    o_rx  = '0;
    r     = (i_rate == CODE_RATE_3) ? 3 : 2;
    rem_i = 32'(i_rem);
    p     = 0;
    for (int j = 0; j < SYM_PER_BEAT; j++) begin
      for (int b = 0; b < MAX_RATE; b++) begin
        p = j * r + b;
        // bits past rem are padding and forced to 0
        if (b < r && p < rem_i) o_rx[j*MAX_RATE+b] = i_top[TOPW-1-p];
      end
    end
  end

`ifdef SLICE_ERASE_EN
  always_comb begin
    int r;
    o_erase = '0;
    r       = (i_rate == CODE_RATE_3) ? 3 : 2;
    for (int j = 0; j < SYM_PER_BEAT; j++)
      o_erase[j] = (j * r >= 32'(i_rem));
  end
`endif
endmodule

// File: rtl/frame_slicer.sv
// frame_slicer: accepts one code frame and emits it MSB-first as beats of
// SYM_PER_BEAT symbols (2 or 3 bits each) under downstream backpressure.
//   clk, rst            : clock, asynchronous active-high reset
//   i_code_rate         : 0 = rate 1/2, 1 = rate 1/3, sampled at accept
//   i_frame_valid/o_frame_ready : frame handshake
//   i_data_frame        : frame bits, MSB consumed first
//   i_frame_len         : valid bits from the MSB (clamped to FRAME_W)
//   o_rx/o_rx_valid/i_rx_ready : beat handshake
//   o_ood               : final beat of the frame
//   o_erase             : per-symbol padding mask (SLICE_ERASE_EN only)
// Optional feature macro: SLICE_ERASE_EN.
module frame_slicer #(
  parameter int FRAME_W      = 276,
  parameter int SYM_PER_BEAT = 2,
  parameter int MAX_RATE     = 3,
  parameter int LEN_W        = $clog2(FRAME_W+1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_code_rate,
  input  logic                             i_frame_valid,
  output logic                             o_frame_ready,
  input  logic [FRAME_W-1:0]               i_data_frame,
  input  logic [LEN_W-1:0]                 i_frame_len,
  output logic [SYM_PER_BEAT*MAX_RATE-1:0] o_rx,
  output logic                             o_rx_valid,
  input  logic                             i_rx_ready,
`ifdef SLICE_ERASE_EN
  output logic [SYM_PER_BEAT-1:0]          o_erase,
`endif
  output logic                             o_ood
);
  import slice_pkg::*;

  localparam int TOPW = SYM_PER_BEAT * MAX_RATE;

  state_e                  r_state;
  logic [FRAME_W-1:0]      r_sr;
  logic [LEN_W-1:0]        r_rem;
  code_rate_e              r_rate;
  logic                    r_ready;
  logic                    r_valid;

  logic [LEN_W-1:0]        w_len_clamp;
  logic [LEN_W-1:0]        w_step;
  logic                    w_last;
  logic [TOPW-1:0]         w_rx;

  assign w_len_clamp = (32'(i_frame_len) > FRAME_W) ? LEN_W'(FRAME_W) : i_frame_len;
  assign w_step      = (r_rate == CODE_RATE_3) ? LEN_W'(SYM_PER_BEAT*3) : LEN_W'(SYM_PER_BEAT*2);
  assign w_last      = (r_rem <= w_step);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_rem   <= '0;
      r_rate  <= CODE_RATE_2;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // a zero-length frame is consumed here and leaves ready high
          if (r_ready && i_frame_valid && w_len_clamp != '0) begin
            r_sr    <= i_data_frame;
            r_rate  <= code_rate_e'(i_code_rate);
            r_rem   <= w_len_clamp;
            r_ready <= 1'b0;
            r_valid <= 1'b1;
            r_state <= RUN;
          end else begin
            r_ready <= 1'b1;
          end
        end
        RUN: begin
          if (i_rx_ready) begin
            r_sr <= r_sr << w_step;
            if (w_last) begin
              r_rem   <= '0;
              r_valid <= 1'b0;
              r_ready <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_rem <= r_rem - w_step;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SLICE_ERASE_EN
  logic [SYM_PER_BEAT-1:0] w_erase;
`endif

  slice_beat_extract #(
    .SYM_PER_BEAT (SYM_PER_BEAT),
    .MAX_RATE     (MAX_RATE),
    .LEN_W        (LEN_W)
  ) u_extract (
    .i_top   (r_sr[FRAME_W-1 -: TOPW]),
    .i_rate  (r_rate),
    .i_rem   (r_rem),
`ifdef SLICE_ERASE_EN
    .o_erase (w_erase),
`endif
    .o_rx    (w_rx)
  );

  // beat outputs are gated so that idle and reset read as all-zero
  assign o_frame_ready = r_ready;
  assign o_rx_valid    = r_valid;
  assign o_rx          = r_valid ? w_rx : '0;
  assign o_ood         = r_valid & w_last;
`ifdef SLICE_ERASE_EN
  assign o_erase       = r_valid ? w_erase : '0;
`endif
endmodule
